// File: rtl/obstacle_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager_pkg
// Purpose  : Shared widths, game state encoding and the obstacle type folding
//            helper for the obstacle manager block.
// Contents : POS_W, TYPE_W, SPEED_W, state_e, map_type()
// Revision : 1.0 - initial release
// ============================================================================
package obstacle_manager_pkg;

   localparam int POS_W   = 9;
   localparam int TYPE_W  = 3;
   localparam int SPEED_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } state_e;

   // Fold a raw 3-bit random value into the legal type range: values at or
   // above the type count are shifted down by the type count.
   function automatic logic [TYPE_W-1:0] map_type(input logic [TYPE_W-1:0] raw,
                                                   input int num_types);
      if (int'(raw) < num_types) begin
         return raw;
      end
      return raw - TYPE_W'(num_types);
   endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_manager_if.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager_if
// Purpose  : Game-control inputs and playfield outputs of the obstacle
//            manager, bundled as one interface.
// Ports    : master - game controller (drives tick/start/over/rng)
//            slave  - obstacle manager (drives obs_* / speed / spawn_pulse)
// Revision : 1.0 - initial release
// ============================================================================
interface obstacle_manager_if #(
   parameter int NUM_OBS = 3
);

   logic                                              game_tick;
   logic                                              game_start;
   logic                                              game_over;
   logic [7:0]                                        rng;
   logic [NUM_OBS-1:0]                                obs_valid;
   logic [obstacle_manager_pkg::POS_W*NUM_OBS-1:0]    obs_pos;
   logic [obstacle_manager_pkg::TYPE_W*NUM_OBS-1:0]   obs_type;
   logic [obstacle_manager_pkg::SPEED_W-1:0]          speed;
   logic                                              spawn_pulse;

   modport master (
      output game_tick, game_start, game_over, rng,
      input  obs_valid, obs_pos, obs_type, speed, spawn_pulse
   );

   modport slave (
      input  game_tick, game_start, game_over, rng,
      output obs_valid, obs_pos, obs_type, speed, spawn_pulse
   );

endinterface
`default_nettype wire

// File: rtl/obstacle_slot.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_slot
// Purpose  : One obstacle slot: holds valid/position/type, scrolls left by
//            the current speed on a move strobe and expires instead of
//            wrapping when the remaining distance is not larger than speed.
// Ports    : clk, rst_n        - clock, async active-low reset
//            i_clear           - drop the slot (game (re)start)
//            i_move            - scroll strobe for this tick
//            i_load            - spawn into this slot (wins over move)
//            i_load_type       - type captured on spawn
//            i_speed           - current scroll speed
//            o_valid/o_pos/o_type - registered slot contents
//            o_expire          - slot would expire on a move this cycle
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_slot
   import obstacle_manager_pkg::*;
#(
   parameter int GEN_LINE = 250
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clear,
   input  logic               i_move,
   input  logic               i_load,
   input  logic [TYPE_W-1:0]  i_load_type,
   input  logic [SPEED_W-1:0] i_speed,
   output logic               o_valid,
   output logic [POS_W-1:0]   o_pos,
   output logic [TYPE_W-1:0]  o_type,
   output logic               o_expire
);

   localparam logic [POS_W-1:0] c_GEN_POS = POS_W'(GEN_LINE);

   logic              valid_q, valid_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [TYPE_W-1:0] type_q, type_d;
   logic [POS_W-1:0]  w_speed_ext;

   assign w_speed_ext = {{(POS_W-SPEED_W){1'b0}}, i_speed};
   assign o_expire    = valid_q && (pos_q <= w_speed_ext);

   always_comb begin
      valid_d = valid_q;
      pos_d   = pos_q;
      type_d  = type_q;
      if (i_clear) begin
         valid_d = 1'b0;
      end else if (i_load) begin
         // A fresh spawn is not scrolled on its own spawn tick.
         valid_d = 1'b1;
         pos_d   = c_GEN_POS;
         type_d  = i_load_type;
      end else if (i_move && valid_q) begin
         if (o_expire) begin
            valid_d = 1'b0;
         end else begin
            pos_d = pos_q - w_speed_ext;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pos_q   <= '0;
         type_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pos_q   <= pos_d;
         type_q  <= type_d;
      end
   end

   assign o_valid = valid_q;
   assign o_pos   = pos_q;
   assign o_type  = type_q;

endmodule
`default_nettype wire

// File: rtl/obstacle_manager.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager
// Purpose  : Runner-game obstacle controller: IDLE/RUN/FROZEN game state,
//            lowest-free-slot spawn arbitration, speed ramp and per-slot
//            scrolling through NUM_OBS obstacle_slot instances.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            bus    - obstacle_manager_if.slave (game_tick, game_start,
//                     game_over, rng in; obs_valid, obs_pos, obs_type,
//                     speed, spawn_pulse out; all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_manager
   import obstacle_manager_pkg::*;
#(
   parameter int NUM_OBS    = 3,
   parameter int GEN_LINE   = 250,
   parameter int MIN_GAP    = 64,
   parameter int NUM_TYPES  = 5,
   parameter int SPEED_MAX  = 7,
   parameter int RAMP_TICKS = 600
) (
   input  logic               clk,
   input  logic               rst_n,
   obstacle_manager_if.slave  bus
);

   localparam int                   c_RAMP_W    = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam logic [c_RAMP_W-1:0]  c_RAMP_LAST = c_RAMP_W'(RAMP_TICKS - 1);
   localparam logic [SPEED_W-1:0]   c_SPEED_MAX = SPEED_W'(SPEED_MAX);
   localparam int                   c_SPAWN_LIM = GEN_LINE - MIN_GAP;

   state_e                state_q, state_d;
   logic [SPEED_W-1:0]    speed_q, speed_d;
   logic [c_RAMP_W-1:0]   ramp_q, ramp_d;
   logic                  spawn_pulse_q, spawn_pulse_d;

   logic                  w_enter_run;
   logic                  w_tick_run;
   logic                  w_blocked;
   logic                  w_spawn;
   logic [TYPE_W-1:0]     w_new_type;
   logic [NUM_OBS-1:0]    w_valid;
   logic [NUM_OBS-1:0]    w_expire;
   logic [NUM_OBS-1:0]    w_free;
   logic [NUM_OBS-1:0]    w_load;
   logic [POS_W-1:0]      w_pos  [NUM_OBS];
   logic [TYPE_W-1:0]     w_type [NUM_OBS];
   logic [POS_W*NUM_OBS-1:0]  w_pos_flat;
   logic [TYPE_W*NUM_OBS-1:0] w_type_flat;
   logic                  w_unused_rng;

   // Only the spawn-enable and type bits of rng carry meaning.
   assign w_unused_rng = ^bus.rng[5:3];

   // game_over wins over game_start only while running; in IDLE/FROZEN a
   // start always (re)enters RUN.
   assign w_enter_run = bus.game_start && !(state_q == ST_RUN && bus.game_over);
   // A tick landing on a start/over cycle is dropped.
   assign w_tick_run  = (state_q == ST_RUN) && bus.game_tick &&
                        !bus.game_start && !bus.game_over;

   assign w_free      = ~w_valid | w_expire;
   assign w_new_type  = map_type(bus.rng[2:0], NUM_TYPES);
   assign w_spawn     = w_tick_run && !w_blocked && (bus.rng[7:6] != 2'b00) && (|w_free);

   // Gap check uses pre-move positions of currently valid slots.
   always_comb begin
      w_blocked = 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (w_valid[i] && (int'(w_pos[i]) > c_SPAWN_LIM)) begin
            w_blocked = 1'b1;
         end
      end
   end

   // Lowest-index slot that is free after this tick's expiries.
   always_comb begin : p_arb
      logic found;
      found  = 1'b0;
      w_load = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (w_free[i] && !found) begin
            w_load[i] = w_spawn;
            found     = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
      obstacle_slot #(
         .GEN_LINE (GEN_LINE)
      ) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_clear     (w_enter_run),
         .i_move      (w_tick_run),
         .i_load      (w_load[gi]),
         .i_load_type (w_new_type),
         .i_speed     (speed_q),
         .o_valid     (w_valid[gi]),
         .o_pos       (w_pos[gi]),
         .o_type      (w_type[gi]),
         .o_expire    (w_expire[gi])
      );
   end

   always_comb begin
      w_pos_flat  = '0;
      w_type_flat = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         w_pos_flat[i*POS_W +: POS_W]    = w_pos[i];
         w_type_flat[i*TYPE_W +: TYPE_W] = w_type[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      speed_d       = speed_q;
      ramp_d        = ramp_q;
      spawn_pulse_d = w_spawn;
      case (state_q)
         ST_IDLE:   if (bus.game_start) state_d = ST_RUN;
         ST_RUN:    if (bus.game_over)  state_d = ST_FROZEN;
                    else if (bus.game_start) state_d = ST_RUN;
         ST_FROZEN: if (bus.game_start) state_d = ST_RUN;
         default:   state_d = ST_IDLE;
      endcase
      if (w_enter_run) begin
         speed_d = SPEED_W'(1);
         ramp_d  = '0;
      end else if (w_tick_run) begin
         if (ramp_q == c_RAMP_LAST) begin
            ramp_d = '0;
            if (speed_q < c_SPEED_MAX) begin
               speed_d = speed_q + SPEED_W'(1);
            end
         end else begin
            ramp_d = ramp_q + c_RAMP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         speed_q       <= SPEED_W'(1);
         ramp_q        <= '0;
         spawn_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         speed_q       <= speed_d;
         ramp_q        <= ramp_d;
         spawn_pulse_q <= spawn_pulse_d;
      end
   end

   assign bus.obs_valid   = w_valid;
   assign bus.obs_pos     = w_pos_flat;
   assign bus.obs_type    = w_type_flat;
   assign bus.speed       = speed_q;
   assign bus.spawn_pulse = spawn_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_manager.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_manager
// Purpose  : Scoreboard bench for obstacle_manager. Two instances: A with
//            default parameters, B with a fast ramp (RAMP_TICKS=4,
//            SPEED_MAX=2). Stimulus pushes hand-computed expectations tagged
//            with the cycle they must be visible in; a monitor pops and
//            compares them.
// Revision : 1.1 - direct reset-value comparisons
// ============================================================================
module tb_obstacle_manager;

    typedef enum int {F_VALID, F_POS0, F_POS1, F_POS2, F_TYPE0, F_TYPE1, F_TYPE2,
                      F_SPEED, F_PULSE} field_e;

    typedef struct {
        int     cyc;      // -1: compare immediately on chk_now
        bit     on_b;
        field_e fld;
        int     exp;
        string  name;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     cyc_cnt = 0;
    int     tgt = 0;
    bit     cur_b = 1'b0;
    int     n_vec = 0;
    int     n_miss = 0;
    exp_t   sb[$];
    event   chk_now;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    obstacle_manager_if #(.NUM_OBS(3)) bus_a();
    obstacle_manager_if #(.NUM_OBS(3)) bus_b();

    obstacle_manager #(
        .NUM_OBS(3), .GEN_LINE(250), .MIN_GAP(64), .NUM_TYPES(5), .SPEED_MAX(7), .RAMP_TICKS(600)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    obstacle_manager #(
        .NUM_OBS(3), .GEN_LINE(250), .MIN_GAP(64), .NUM_TYPES(5), .SPEED_MAX(2), .RAMP_TICKS(4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    function automatic int sample(input bit b, input field_e f);
        logic [2:0]  v;
        logic [26:0] p;
        logic [8:0]  t;
        logic [3:0]  s;
        logic        sp;
        v  = b ? bus_b.obs_valid   : bus_a.obs_valid;
        p  = b ? bus_b.obs_pos     : bus_a.obs_pos;
        t  = b ? bus_b.obs_type    : bus_a.obs_type;
        s  = b ? bus_b.speed       : bus_a.speed;
        sp = b ? bus_b.spawn_pulse : bus_a.spawn_pulse;
        case (f)
            F_VALID: return int'(v);
            F_POS0:  return int'(p[8:0]);
            F_POS1:  return int'(p[17:9]);
            F_POS2:  return int'(p[26:18]);
            F_TYPE0: return int'(t[2:0]);
            F_TYPE1: return int'(t[5:3]);
            F_TYPE2: return int'(t[8:6]);
            F_SPEED: return int'(s);
            default: return int'(sp);
        endcase
    endfunction

    task automatic chk(input field_e f, input int v, input string nm);
        exp_t e;
        e.cyc  = tgt;
        e.on_b = cur_b;
        e.fld  = f;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs to the selected instance; tgt becomes the
    // cycle in which the registered response is visible.
    task automatic drive(input bit b, input bit tk, input bit st, input bit ov,
                         input logic [7:0] r);
        cur_b = b;
        if (b) begin
            bus_b.game_tick = tk; bus_b.game_start = st; bus_b.game_over = ov; bus_b.rng = r;
        end else begin
            bus_a.game_tick = tk; bus_a.game_start = st; bus_a.game_over = ov; bus_a.rng = r;
        end
        tgt = cyc_cnt + 1;
        @(posedge clk);
        #1;
        bus_a.game_tick = 1'b0; bus_a.game_start = 1'b0; bus_a.game_over = 1'b0;
        bus_b.game_tick = 1'b0; bus_b.game_start = 1'b0; bus_b.game_over = 1'b0;
    endtask

    task automatic tick(input bit b, input logic [7:0] r);
        drive(b, 1'b1, 1'b0, 1'b0, r);
    endtask

    // Monitor: compare every expectation whose visibility cycle has come.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() > 0 && (sb[0].cyc < 0 || sb[0].cyc <= cyc_cnt)) begin
                e   = sb.pop_front();
                act = sample(e.on_b, e.fld);
                n_vec++;
                if (act != e.exp) begin
                    n_miss++;
                    $display("FAIL %s (dut %s, cycle %0d): got %0d, expected %0d",
                             e.name, e.on_b ? "B" : "A", cyc_cnt, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d expectations pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bus_a.game_tick = 1'b0; bus_a.game_start = 1'b0; bus_a.game_over = 1'b0; bus_a.rng = 8'h00;
        bus_b.game_tick = 1'b0; bus_b.game_start = 1'b0; bus_b.game_over = 1'b0; bus_b.rng = 8'h00;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.obs_valid !== 3'b000) begin
            n_miss++;
            $display("FAIL direct_rst_valid_a: got %0b", bus_a.obs_valid);
        end
        n_vec++;
        if (bus_a.obs_pos !== 27'd0) begin
            n_miss++;
            $display("FAIL direct_rst_pos_a: got %0h", bus_a.obs_pos);
        end
        n_vec++;
        if (bus_a.obs_type !== 9'd0) begin
            n_miss++;
            $display("FAIL direct_rst_type_a: got %0h", bus_a.obs_type);
        end
        n_vec++;
        if (bus_a.speed !== 4'd1) begin
            n_miss++;
            $display("FAIL direct_rst_speed_a: got %0d", bus_a.speed);
        end
        n_vec++;
        if (bus_a.spawn_pulse !== 1'b0) begin
            n_miss++;
            $display("FAIL direct_rst_pulse_a: got %0b", bus_a.spawn_pulse);
        end
        n_vec++;
        if (bus_b.obs_valid !== 3'b000) begin
            n_miss++;
            $display("FAIL direct_rst_valid_b: got %0b", bus_b.obs_valid);
        end
        n_vec++;
        if (bus_b.speed !== 4'd1) begin
            n_miss++;
            $display("FAIL direct_rst_speed_b: got %0d", bus_b.speed);
        end
        tgt = cyc_cnt; cur_b = 1'b0;
        chk(F_VALID, 0, "rst_valid"); chk(F_POS0, 0, "rst_pos0"); chk(F_TYPE0, 0, "rst_type0");
        chk(F_SPEED, 1, "rst_speed"); chk(F_PULSE, 0, "rst_pulse");
        cur_b = 1'b1; chk(F_SPEED, 1, "rst_speed_b");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- instance A ----------------
        for (int i = 0; i < 5; i++) begin
            tick(0, 8'hC3);
            chk(F_VALID, 0, "idle_valid"); chk(F_PULSE, 0, "idle_pulse");
        end
        chk(F_SPEED, 1, "idle_speed");

        drive(0, 1'b0, 1'b1, 1'b0, 8'hC3);
        chk(F_VALID, 0, "start_valid"); chk(F_SPEED, 1, "start_speed");

        tick(0, 8'hC3);
        chk(F_VALID, 1, "spawn0_valid"); chk(F_POS0, 250, "spawn0_pos"); chk(F_TYPE0, 3, "spawn0_type");
        chk(F_PULSE, 1, "spawn0_pulse");
        drive(0, 1'b0, 1'b0, 1'b0, 8'hC7);
        chk(F_PULSE, 0, "pulse_one_cycle"); chk(F_POS0, 250, "no_tick_hold");

        for (int j = 1; j <= 64; j++) begin
            tick(0, 8'hC7);
            chk(F_VALID, 1, "gap_valid"); chk(F_PULSE, 0, "gap_pulse");
            if (j == 1) chk(F_POS0, 249, "first_move");
        end
        chk(F_POS0, 186, "gap_pos0");

        tick(0, 8'h07);
        chk(F_VALID, 1, "rng_gate_valid"); chk(F_POS0, 185, "rng_gate_pos0"); chk(F_PULSE, 0, "rng_gate_pulse");

        tick(0, 8'hC7);
        chk(F_VALID, 3, "spawn1_valid"); chk(F_POS1, 250, "spawn1_pos"); chk(F_TYPE1, 2, "spawn1_type");
        chk(F_POS0, 184, "spawn1_pos0"); chk(F_PULSE, 1, "spawn1_pulse");

        for (int j = 0; j < 64; j++) tick(0, 8'hC7);
        chk(F_VALID, 3, "gap1_valid"); chk(F_POS1, 186, "gap1_pos1"); chk(F_POS0, 120, "gap1_pos0");

        tick(0, 8'hC7);
        chk(F_VALID, 7, "spawn2_valid"); chk(F_POS2, 250, "spawn2_pos"); chk(F_TYPE2, 2, "spawn2_type");
        chk(F_POS1, 185, "spawn2_pos1"); chk(F_PULSE, 1, "spawn2_pulse");

        for (int j = 0; j < 64; j++) tick(0, 8'hC7);
        chk(F_POS2, 186, "gap2_pos2"); chk(F_POS0, 55, "gap2_pos0");

        tick(0, 8'hC7);
        chk(F_VALID, 7, "full_valid"); chk(F_PULSE, 0, "full_pulse"); chk(F_POS0, 54, "full_pos0");
        chk(F_POS2, 185, "full_pos2");

        for (int j = 0; j < 53; j++) tick(0, 8'h07);
        chk(F_POS0, 1, "pre_expire_pos0"); chk(F_VALID, 7, "pre_expire_valid");

        tick(0, 8'h07);
        chk(F_VALID, 6, "expire_valid"); chk(F_POS1, 66, "expire_pos1"); chk(F_POS2, 131, "expire_pos2");
        chk(F_PULSE, 0, "expire_pulse"); chk(F_SPEED, 1, "expire_speed");

        // asynchronous reset mid-cycle, away from any clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus_a.obs_valid !== 3'b000) begin
            n_miss++;
            $display("FAIL direct_arst_valid: got %0b", bus_a.obs_valid);
        end
        n_vec++;
        if (bus_a.obs_pos !== 27'd0) begin
            n_miss++;
            $display("FAIL direct_arst_pos: got %0h", bus_a.obs_pos);
        end
        n_vec++;
        if (bus_a.speed !== 4'd1) begin
            n_miss++;
            $display("FAIL direct_arst_speed: got %0d", bus_a.speed);
        end
        tgt = -1; cur_b = 1'b0;
        chk(F_VALID, 0, "arst_valid"); chk(F_POS1, 0, "arst_pos1"); chk(F_POS2, 0, "arst_pos2");
        chk(F_TYPE1, 0, "arst_type1"); chk(F_SPEED, 1, "arst_speed"); chk(F_PULSE, 0, "arst_pulse");
        ->chk_now;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        tick(0, 8'hC3);
        chk(F_VALID, 0, "post_rst_idle_valid"); chk(F_PULSE, 0, "post_rst_idle_pulse");
        drive(0, 1'b0, 1'b1, 1'b0, 8'hC3);
        tick(0, 8'hC3);
        chk(F_VALID, 1, "post_rst_spawn_valid"); chk(F_PULSE, 1, "post_rst_spawn_pulse");

        // ---------------- instance B: ramp and game control ----------------
        drive(1, 1'b0, 1'b1, 1'b0, 8'h07);
        chk(F_VALID, 0, "b_start_valid"); chk(F_SPEED, 1, "b_start_speed");

        tick(1, 8'hC3);
        chk(F_VALID, 1, "b_spawn_valid"); chk(F_POS0, 250, "b_spawn_pos"); chk(F_SPEED, 1, "b_spawn_speed");
        tick(1, 8'h07);
        tick(1, 8'h07);
        chk(F_SPEED, 1, "b_ramp3_speed"); chk(F_POS0, 248, "b_ramp3_pos");
        tick(1, 8'h07);
        chk(F_SPEED, 2, "b_ramp4_speed"); chk(F_POS0, 247, "b_ramp4_pos");

        for (int j = 0; j < 8; j++) begin
            tick(1, 8'h07);
            chk(F_SPEED, 2, "b_sat_speed");
        end
        chk(F_POS0, 231, "b_sat_pos");

        drive(1, 1'b1, 1'b0, 1'b1, 8'hC3);
        chk(F_POS0, 231, "b_over_tick_pos"); chk(F_VALID, 1, "b_over_valid"); chk(F_SPEED, 2, "b_over_speed");
        tick(1, 8'hC3);
        chk(F_POS0, 231, "b_frozen_pos"); chk(F_VALID, 1, "b_frozen_valid"); chk(F_PULSE, 0, "b_frozen_pulse");

        drive(1, 1'b1, 1'b1, 1'b0, 8'hC3);
        chk(F_VALID, 0, "b_restart_valid"); chk(F_SPEED, 1, "b_restart_speed"); chk(F_PULSE, 0, "b_restart_pulse");
        tick(1, 8'hC3);
        chk(F_VALID, 1, "b_rerun_valid"); chk(F_POS0, 250, "b_rerun_pos"); chk(F_PULSE, 1, "b_rerun_pulse");

        drive(1, 1'b0, 1'b1, 1'b1, 8'hC3);
        chk(F_VALID, 1, "b_over_wins_valid");
        tick(1, 8'hC3);
        chk(F_POS0, 250, "b_over_wins_pos"); chk(F_PULSE, 0, "b_over_wins_pulse");
        drive(1, 1'b0, 1'b1, 1'b0, 8'hC3);
        chk(F_VALID, 0, "b_final_valid"); chk(F_SPEED, 1, "b_final_speed");

        // ---------------- drain ----------------
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL %s: never compared, expected %0d", e.name, e.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obstacle_manager.md
OBSTACLE_MANAGER -- requirements
Module: obstacle_manager

Interface
REQ-001 Parameter NUM_OBS, default 3, SHALL set the number of independent obstacle slots (1..8).
REQ-002 Parameter GEN_LINE, default 250, SHALL set the 9-bit x position at which obstacles spawn.
REQ-003 Parameter MIN_GAP, default 64, SHALL set the minimum x distance between consecutive spawns.
REQ-004 Parameter NUM_TYPES, default 5, SHALL set the number of legal obstacle types (1..8).
REQ-005 Parameter SPEED_MAX, default 7, SHALL set the saturating scroll speed in pixels per tick (1..15).
REQ-006 Parameter RAMP_TICKS, default 600, SHALL set the number of RUN ticks per speed increment.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 game_tick  input  1  one-cycle frame-tick pulse in the clk domain.
REQ-010 game_start  input  1  one-cycle pulse that starts or restarts a game.
REQ-011 game_over  input  1  one-cycle pulse that freezes the playfield.
REQ-012 rng  input  8  free-running pseudo-random value, sampled on game_tick.
REQ-013 obs_valid  output  NUM_OBS  per-slot occupied flag.
REQ-014 obs_pos  output  9*NUM_OBS  per-slot x position; slot i at bits [9i+8:9i].
REQ-015 obs_type  output  3*NUM_OBS  per-slot type; slot i at bits [3i+2:3i].
REQ-016 speed  output  4  current scroll speed.
REQ-017 spawn_pulse  output  1  one-cycle pulse on the cycle a new obstacle becomes visible.

Function
REQ-018 The block SHALL implement states IDLE, RUN, FROZEN.
REQ-019 IDLE: game_tick is ignored; game_start -> RUN.
REQ-020 RUN: game_over -> FROZEN; game_start -> RUN with all slots cleared and speed=1; game_over wins when both are asserted in the same cycle.
REQ-021 FROZEN: positions, types and speed hold; game_start -> RUN with all slots cleared and speed=1.
REQ-022 Every entry into RUN SHALL clear obs_valid, zero the ramp counter and set speed=1 on the following cycle.
REQ-023 On game_tick in RUN, each valid slot with pos > speed SHALL become pos-speed; a valid slot with pos <= speed SHALL become invalid (no wrap-around).
REQ-024 Spawn eligibility, evaluated with pre-move positions: no valid slot has pos > GEN_LINE-MIN_GAP, rng[7:6] != 2'b00, and at least one slot is free after this tick's expiries.
REQ-025 On an eligible tick the lowest-index free slot SHALL load pos=GEN_LINE, valid=1, type=rng[2:0] if < NUM_TYPES, else rng[2:0]-NUM_TYPES; the new slot is not moved on its spawn tick.
REQ-026 If all slots are full, a spawn SHALL be skipped silently.
REQ-027 The ramp counter SHALL count RUN ticks; on reaching RAMP_TICKS-1 it wraps to 0 and speed increments, saturating at SPEED_MAX.
REQ-028 All outputs SHALL be registered; a tick's effects are visible exactly one cycle after the game_tick cycle.
REQ-029 spawn_pulse SHALL assert for exactly that one visibility cycle.
REQ-030 game_tick coincident with game_over or game_start SHALL be discarded.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE, obs_valid=0, obs_pos=0, obs_type=0, speed=1, spawn_pulse=0, ramp counter=0.
REQ-032 Reset asserted mid-game SHALL take effect immediately, without waiting for clk; the block SHALL leave reset in IDLE.

Structure
REQ-033 A shared package SHALL hold the state enumeration, POS_W=9, TYPE_W=3, SPEED_W=4.
REQ-034 Per-slot position/valid/type storage and move/expire logic SHALL be one sub-module, obstacle_slot, instantiated NUM_OBS times.
REQ-035 Spawn arbitration (lowest free index), the ramp counter and the FSM SHALL reside in obstacle_manager.

Verification
REQ-036 Reset, then 5 ticks with no game_start -> obs_valid=000, speed=1, spawn_pulse never asserted.
REQ-037 game_start, then tick with rng=8'hC3 -> next cycle slot0 valid, pos=250, type=3, spawn_pulse=1; next tick -> pos=249.
REQ-038 rng held at 8'hC7 across ticks -> slot1 spawns (type 2) only on the tick after slot0 reaches pos<=186; rng=8'h07 at that tick -> no spawn.
REQ-039 Slot at pos=1 with speed=1, tick -> slot becomes invalid; with all 3 slots full on an eligible tick -> no spawn, no spawn_pulse.
REQ-040 RAMP_TICKS=4, SPEED_MAX=2: 4 RUN ticks -> speed=2; 8 more -> speed remains 2; game_over then tick -> positions unchanged; game_start -> obs_valid=000, speed=1.
REQ-041 rst_n low while 2 slots are valid in RUN -> outputs at reset values without a clk edge; state IDLE after release.
